closest_hit: RTL and testbench

// - Downstream reducer for the triangle intersection stage.
// - Consumes the in-order stream of per-triangle results (t, result, valid) for one ray.
// - Tracks the nearest valid hit and its triangle index.
// - Reports the committed closest hit once all triangles of the ray have returned.
// - Feeds the shading / ray-writeback stage.

---
 rtl/closest_hit_if.sv | 27 ++
 rtl/closest_hit.sv | 89 ++++++++
 tb/tb_closest_hit.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/closest_hit_if.sv
// Result stream from the intersection stage and committed closest-hit report.
interface closest_hit_if #(
    parameter int IDX_W = 16,
    parameter int T_W   = 32
);
    logic             i_start;
    logic [IDX_W-1:0] i_num_tris;
    logic             i_valid;
    logic             i_result;
    logic [T_W-1:0]   i_t;
    logic             o_busy;
    logic             o_done;
    logic             o_hit;
    logic [T_W-1:0]   o_t;
    logic [IDX_W-1:0] o_tri_idx;
    logic             o_err;

    modport master (
        output i_start, i_num_tris, i_valid, i_result, i_t,
        input  o_busy, o_done, o_hit, o_t, o_tri_idx, o_err
    );

    modport slave (
        input  i_start, i_num_tris, i_valid, i_result, i_t,
        output o_busy, o_done, o_hit, o_t, o_tri_idx, o_err
    );
endinterface

// File: rtl/closest_hit.sv
// Reduces one ray's in-order intersection results to the nearest valid hit.
// Commits hit/t/index with a one-cycle done pulse when the last result lands.
module closest_hit #(
    parameter int             IDX_W = 16,
    parameter int             T_W   = 32,
    parameter logic [T_W-1:0] T_MAX = 32'h7FFF_FFFF
) (
    input logic          i_clk,
    input logic          i_rstn,
    closest_hit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                state, state_nx;
    logic [IDX_W-1:0]      n, count, best_idx;
    logic signed [T_W-1:0] best_t;
    logic                  best_hit;
    logic                  start, zero, accept, last, take;

    assign start  = bus.i_start;
    assign zero   = (bus.i_num_tris == '0);
    assign accept = bus.i_valid && (state == ACCUM) && !start;
    assign last   = accept && (count == n - 1'b1);
    // Strict compare keeps the earlier index on ties
    assign take   = accept && bus.i_result &&
                    ($signed(bus.i_t) < best_t) &&
                    ($signed(bus.i_t) < $signed(T_MAX));

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  state_nx = IDLE;
            ACCUM: if (last) state_nx = DONE;
            DONE:  state_nx = IDLE;
        endcase
        // A start aborts any ray in flight
        if (start) state_nx = zero ? DONE : ACCUM;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            n         <= '0;
            count     <= '0;
            best_t    <= T_MAX;
            best_idx  <= '0;
            best_hit  <= 1'b0;
            bus.o_hit     <= 1'b0;
            bus.o_t       <= T_MAX;
            bus.o_tri_idx <= '0;
            bus.o_err     <= 1'b0;
        end else begin
            if (start) begin
                n        <= bus.i_num_tris;
                count    <= '0;
                best_t   <= T_MAX;
                best_idx <= '0;
                best_hit <= 1'b0;
            end else if (accept) begin
                count <= count + 1'b1;
                if (take) begin
                    best_t   <= $signed(bus.i_t);
                    best_idx <= count;
                    best_hit <= 1'b1;
                end
            end

            if (start && zero) begin
                bus.o_hit     <= 1'b0;
                bus.o_t       <= T_MAX;
                bus.o_tri_idx <= '0;
            end else if (last) begin
                bus.o_hit     <= best_hit || take;
                bus.o_t       <= take ? bus.i_t : best_t;
                bus.o_tri_idx <= take ? count : best_idx;
            end

            if (bus.i_valid && (state != ACCUM || start))
                bus.o_err <= 1'b1;
        end
    end

    assign bus.o_busy = (state == ACCUM);
    assign bus.o_done = (state == DONE);
endmodule

// File: tb/tb_closest_hit.sv
// Directed and randomized rays checked against a min-search reference model.
module tb_closest_hit;
    localparam logic [31:0] TMAX = 32'h7FFF_FFFF;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;

    logic        res_q[$];
    logic [31:0] t_q[$];

    closest_hit_if #(.IDX_W(16), .T_W(32)) bus ();

    closest_hit dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Nearest hit: smallest signed t among hits below the far clip,
    // then the first arrival carrying that t.
    task automatic model(output logic eh, output logic [31:0] et,
                         output logic [31:0] ei);
        eh = 1'b0;
        et = TMAX;
        ei = 0;
        foreach (t_q[i])
            if (res_q[i] && t_q[i] != TMAX) begin
                if (!eh || $signed(t_q[i]) < $signed(et)) et = t_q[i];
                eh = 1'b1;
            end
        if (eh)
            for (int i = t_q.size() - 1; i >= 0; i--)
                if (res_q[i] && t_q[i] == et) ei = i;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, bus.o_busy, 0);
        chk({tag, "_done"}, bus.o_done, 0);
        chk({tag, "_hit"}, bus.o_hit, 0);
        chk({tag, "_t"}, bus.o_t, TMAX);
        chk({tag, "_idx"}, bus.o_tri_idx, 0);
        chk({tag, "_err"}, bus.o_err, 0);
    endtask

    task automatic feed(input string tag);
        logic eh;
        logic [31:0] et, ei;
        int n;
        n = t_q.size();
        model(eh, et, ei);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_busy"}, bus.o_busy, 1);
            bus.i_valid  = 1'b1;
            bus.i_result = res_q[i];
            bus.i_t      = t_q[i];
            tick();
            if (i < n - 1) chk({tag, "_early_done"}, bus.o_done, 0);
        end
        bus.i_valid = 1'b0;
        chk({tag, "_done"}, bus.o_done, 1);
        chk({tag, "_busy_off"}, bus.o_busy, 0);
        chk({tag, "_hit"}, bus.o_hit, eh);
        chk({tag, "_t"}, bus.o_t, et);
        chk({tag, "_idx"}, bus.o_tri_idx, ei);
        chk({tag, "_err"}, bus.o_err, 0);
        tick();
        chk({tag, "_done_pulse"}, bus.o_done, 0);
        chk({tag, "_hold_t"}, bus.o_t, et);
    endtask

    task automatic start_ray(input int n);
        bus.i_start    = 1'b1;
        bus.i_num_tris = 16'(n);
        tick();
        bus.i_start = 1'b0;
    endtask

    task automatic run_ray(input string tag);
        start_ray(t_q.size());
        feed(tag);
    endtask

    task automatic push(input logic r, input logic [31:0] t);
        res_q.push_back(r);
        t_q.push_back(t);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #2;
        rstn = 1'b1;
        tick();
    endtask

    initial begin
        bus.i_start    = 1'b0;
        bus.i_num_tris = '0;
        bus.i_valid    = 1'b0;
        bus.i_result   = 1'b0;
        bus.i_t        = '0;
        repeat (2) tick();
        chk_reset_vals("reset");
        rstn = 1'b1;
        tick();

        res_q = {}; t_q = {};
        push(1, 180224); push(1, 65536); push(0, 32'hDEAD_BEEF);
        run_ray("basic3");

        res_q = {}; t_q = {};
        repeat (4) push(0, 1000);
        run_ray("allmiss");

        res_q = {}; t_q = {};
        push(1, 65536); push(1, 65536);
        run_ray("tie");

        res_q = {}; t_q = {};
        push(1, TMAX);
        run_ray("farclip");

        res_q = {}; t_q = {};
        push(1, 32'hFFFF_0000); push(1, 65536); push(1, 32'h8000_0000);
        run_ray("negative");

        start_ray(0);
        chk("zero_done", bus.o_done, 1);
        chk("zero_busy", bus.o_busy, 0);
        chk("zero_hit", bus.o_hit, 0);
        chk("zero_t", bus.o_t, TMAX);
        chk("zero_idx", bus.o_tri_idx, 0);
        tick();
        chk("zero_pulse", bus.o_done, 0);

        start_ray(3);
        bus.i_valid = 1'b1; bus.i_result = 1'b1; bus.i_t = 65536;
        tick();
        bus.i_valid = 1'b0;
        chk("abort_nodone0", bus.o_done, 0);
        start_ray(2);
        chk("abort_nodone1", bus.o_done, 0);
        res_q = {}; t_q = {};
        push(1, 131072); push(1, 196608);
        feed("abort");

        for (int r = 0; r < 40; r++) begin
            int n;
            n = $urandom_range(1, 8);
            res_q = {}; t_q = {};
            for (int i = 0; i < n; i++) begin
                logic [31:0] t;
                case ($urandom_range(0, 3))
                    0: t = $urandom;
                    1: t = ($urandom_range(0, 1) != 0) ? 32'd65536 : 32'hFFFF_0000;
                    2: t = TMAX;
                    default: t = {1'b0, 31'($urandom)};
                endcase
                push(1'($urandom_range(0, 1)), t);
            end
            run_ray($sformatf("rand%0d", r));
        end

        bus.i_valid = 1'b1; bus.i_result = 1'b1; bus.i_t = 5;
        tick();
        bus.i_valid = 1'b0;
        chk("idle_valid_err", bus.o_err, 1);
        chk("idle_valid_nodone", bus.o_done, 0);
        tick();
        chk("err_sticky", bus.o_err, 1);
        do_reset();
        chk("err_cleared", bus.o_err, 0);

        res_q = {}; t_q = {};
        push(1, 4096);
        run_ray("prereset");
        start_ray(4);
        bus.i_valid = 1'b1; bus.i_result = 1'b1; bus.i_t = 100;
        tick(); tick();
        bus.i_valid = 1'b0;
        rstn = 1'b0;
        #1;
        chk_reset_vals("midreset");
        rstn = 1'b1;
        tick();
        chk("midreset_nodone", bus.o_done, 0);
        res_q = {}; t_q = {};
        push(0, 7); push(1, 300000); push(1, 200000);
        run_ray("postreset");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule
